// File: rtl/fir_pkg.sv
// Shared constants and width helpers for the parameterised FIR filter.
//   fir_clog2 : ceiling log2, used for tap address and accumulator growth
//   fir_acc_w : full-precision accumulator width for a given configuration
package fir_pkg;

    localparam int unsigned FIR_DATA_W_DEF = 8;
    localparam int unsigned FIR_COEF_W_DEF = 8;
    localparam int unsigned FIR_NTAPS_DEF  = 9;

    // Ceiling log2; returns 1 for n = 2, 4 for n = 9, 5 for n = 32.
    function automatic int unsigned fir_clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Product width plus growth from summing ntaps products.
    function automatic int unsigned fir_acc_w(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned ntaps);
        return data_w + coef_w + fir_clog2(ntaps);
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Combinational pairwise adder tree summing NTAPS signed products.
//   terms : NTAPS signed inputs, IN_W bits each
//   sum_c : signed full-precision sum, OUT_W bits (combinational)
module fir_adder_tree
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS = FIR_NTAPS_DEF,
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = IN_W + fir_clog2(NTAPS)
) (
    input  logic signed [IN_W-1:0]  terms [NTAPS],
    output logic signed [OUT_W-1:0] sum_c
);

    localparam int unsigned LEAVES = 1 << fir_clog2(NTAPS);

    logic signed [OUT_W-1:0] node [LEAVES];

    // Leaves are sign-extended terms padded with zeros to a power of two;
    // each pass halves the live width, writing below the indices it reads.
    always_comb begin
        for (int i = 0; i < int'(LEAVES); i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < int'(NTAPS); i++) begin
            node[i] = OUT_W'(terms[i]);
        end
        for (int w = int'(LEAVES) / 2; w > 0; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                node[i] = node[2*i] + node[2*i+1];
            end
        end
        sum_c = node[0];
    end

endmodule

// File: rtl/fir_param.sv
// Parameterised 3-stage pipelined FIR filter with writable coefficients.
//   clk, rst  : clock and synchronous active-high reset
//   din, vin  : signed input sample and its one-cycle qualifier
//   coef_we, coef_addr, coef_data : coefficient write port (tap 0 = newest)
//   dout, vout: signed filtered sample (shifted, saturated) and qualifier
// Stages: delay line -> product registers -> sum/saturate/output register.
module fir_param
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = FIR_DATA_W_DEF,
    parameter int unsigned COEF_W = FIR_COEF_W_DEF,
    parameter int unsigned NTAPS  = FIR_NTAPS_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [DATA_W-1:0]        din,
    input  logic                            vin,
    input  logic                            coef_we,
    input  logic [fir_clog2(NTAPS)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]        coef_data,
    output logic signed [DATA_W-1:0]        dout,
    output logic                            vout
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = fir_acc_w(DATA_W, COEF_W, NTAPS);

    // Output range expressed at accumulator width for signed compares.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        signed'({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        signed'({{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

    logic signed [DATA_W-1:0] taps  [NTAPS];
    logic signed [COEF_W-1:0] coefs [NTAPS];
    logic signed [PROD_W-1:0] prods [NTAPS];
    logic                     v1;
    logic                     v2;

    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  shifted_c;
    logic signed [DATA_W-1:0] sat_c;

    // Stage 1: delay line advances only on accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NTAPS); k++) begin
                taps[k] <= '0;
            end
            v1 <= 1'b0;
        end else begin
            if (vin) begin
                taps[0] <= din;
                for (int k = 1; k < int'(NTAPS); k++) begin
                    taps[k] <= taps[k-1];
                end
            end
            v1 <= vin;
        end
    end

    // Coefficient bank; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NTAPS); k++) begin
                coefs[k] <= '0;
            end
        end else if (coef_we && (32'(coef_addr) < NTAPS)) begin
            coefs[coef_addr] <= coef_data;
        end
    end

    // Stage 2: full-precision products, captured only for live samples so a
    // coefficient write never disturbs a sample already at this stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(NTAPS); k++) begin
                prods[k] <= '0;
            end
            v2 <= 1'b0;
        end else begin
            if (v1) begin
                for (int k = 0; k < int'(NTAPS); k++) begin
                    prods[k] <= PROD_W'(taps[k]) * PROD_W'(coefs[k]);
                end
            end
            v2 <= v1;
        end
    end

    fir_adder_tree #(
        .NTAPS (NTAPS),
        .IN_W  (PROD_W),
        .OUT_W (ACC_W)
    ) u_tree (
        .terms (prods),
        .sum_c (sum_c)
    );

    // Drop the Q1.(COEF_W-1) fraction with floor rounding, then clamp.
    always_comb begin
        shifted_c = sum_c >>> (COEF_W - 1);
        sat_c     = DATA_W'(shifted_c);
        if (shifted_c > SAT_MAX) begin
            sat_c = DATA_W'(SAT_MAX);
        end else if (shifted_c < SAT_MIN) begin
            sat_c = DATA_W'(SAT_MIN);
        end
    end

    // Stage 3: output register holds between produced samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            vout <= 1'b0;
        end else begin
            if (v2) begin
                dout <= sat_c;
            end
            vout <= v2;
        end
    end

endmodule
